// File: rtl/bus_pkg.sv
// Shared types and decode constants for the fx68k bus cycle controller.
package bus_pkg;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_RAM,
    REG_LED,
    REG_PERIPH,
    REG_NONE
  } region_t;

  localparam logic [3:0] ROM_BASE    = 4'h0;
  localparam logic [3:0] RAM_BASE    = 4'h1;
  localparam logic [3:0] LED_BASE    = 4'h2;
  localparam logic [5:0] PERIPH_BASE = 6'b011000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BERR,
    S_LDR
  } state_t;

endpackage

// File: rtl/bus_decode.sv
// Combinational CPU address decode into a region, qualified by the address strobe.
module bus_decode
  import bus_pkg::*;
(
  input  logic [23:12] addr_hi,
  input  logic         as_n,
  output region_t      region,
  output logic         vpa_n
);

  always_comb begin
    region = REG_NONE;
    if (!as_n) begin
      if (addr_hi[23:18] == PERIPH_BASE) begin
        region = REG_PERIPH;
      end else if (addr_hi[23:16] == 8'h00) begin
        case (addr_hi[15:12])
          ROM_BASE: region = REG_ROM;
          RAM_BASE: region = REG_RAM;
          LED_BASE: region = REG_LED;
          default:  region = REG_NONE;
        endcase
      end
    end
  end

  assign vpa_n = (region != REG_PERIPH);

endmodule

// File: rtl/bus_ctrl.sv
// fx68k bus cycle controller: wait-state insertion, DTACKn/BERRn generation
// and work RAM sharing with a loader between CPU bus cycles.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 1,
  parameter int TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:1] cpu_addr,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        vpa_n,
  output logic        rom_cs,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        ram_we,
  output logic [1:0]  ram_mask,
  output logic [10:0] ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic        led_we,
  input  logic        ldr_req,
  input  logic [10:0] ldr_addr,
  input  logic [15:0] ldr_din,
  output logic        ldr_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  region_t         region;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err, err_n;
  logic            strobe;

  bus_decode u_decode (
    .addr_hi (cpu_addr[23:12]),
    .as_n    (cpu_as_n),
    .region  (region),
    .vpa_n   (vpa_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      dtack_n <= 1'b1;
      berr_n  <= 1'b1;
      ldr_ack <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      err     <= err_n;
      dtack_n <= (state_n != S_ACK);
      berr_n  <= (state_n != S_BERR);
      ldr_ack <= (state == S_LDR);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    case (state)
      S_IDLE: begin
        if (!cpu_as_n) begin
          // Peripheral cycles are terminated by VPA, so the FSM stays put.
          case (region)
            REG_ROM: begin
              state_n = S_WAIT;
              cnt_n   = CW'(ROM_WAIT);
              err_n   = 1'b0;
            end
            REG_RAM, REG_LED: begin
              state_n = S_WAIT;
              cnt_n   = CW'(RAM_WAIT);
              err_n   = 1'b0;
            end
            REG_NONE: begin
              state_n = S_WAIT;
              cnt_n   = CW'(TIMEOUT);
              err_n   = 1'b1;
            end
            default: ;
          endcase
        end else if (ldr_req) begin
          state_n = S_LDR;
        end
      end
      S_WAIT: begin
        if (cpu_as_n) begin
          state_n = S_IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = err ? S_BERR : S_ACK;
        end
      end
      S_ACK, S_BERR: begin
        if (cpu_as_n) state_n = S_IDLE;
      end
      S_LDR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Write strobes fire in the last wait cycle so memory captures before DTACKn.
  assign strobe = (state == S_WAIT) && (cnt == '0) && !cpu_rw && !err;

  always_comb begin
    ram_we   = (strobe && region == REG_RAM) || (state == S_LDR);
    led_we   = strobe && region == REG_LED;
    ram_mask = {!cpu_uds_n, !cpu_lds_n};
    ram_addr = cpu_addr[11:1];
    ram_din  = cpu_dout;
    if (state == S_LDR) begin
      ram_mask = 2'b11;
      ram_addr = ldr_addr;
      ram_din  = ldr_din;
    end
  end

  assign rom_cs   = (region == REG_ROM);
  assign rom_addr = cpu_addr[8:1];
  assign cpu_din  = (region == REG_RAM) ? ram_dout : rom_dout;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl with a transaction-level timing model checked every cycle.
module tb_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:1] cpu_addr;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [15:0] cpu_dout, cpu_din;
  logic        dtack_n, berr_n, vpa_n, rom_cs;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout, ram_dout, ram_din, ldr_din;
  logic        ram_we, led_we, ldr_req, ldr_ack;
  logic [1:0]  ram_mask;
  logic [10:0] ram_addr, ldr_addr;

  int checks = 0;
  int errors = 0;

  bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(1), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack_n(dtack_n), .berr_n(berr_n),
    .vpa_n(vpa_n), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .ram_we(ram_we), .ram_mask(ram_mask), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .led_we(led_we), .ldr_req(ldr_req), .ldr_addr(ldr_addr),
    .ldr_din(ldr_din), .ldr_ack(ldr_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 ROM, 1 RAM, 2 LED, 3 PERIPH, 4 unmapped
  function automatic int region_of(input logic [23:0] a);
    if (a < 24'h001000) return 0;
    if (a < 24'h002000) return 1;
    if (a < 24'h003000) return 2;
    if (a >= 24'h600000 && a < 24'h640000) return 3;
    return 4;
  endfunction

  // Transaction model: a cycle starts at edge 'start' and terminates after edge 'target'.
  int k = 0;
  int target = 0;
  int ldr_edge = -10;
  bit busy = 0, err_m = 0;

  always @(posedge clk) begin
    int r;
    k++;
    r = region_of({cpu_addr, 1'b0});
    if (rst) begin
      busy = 0;
      ldr_edge = -10;
    end else if (busy) begin
      if (cpu_as_n) busy = 0;
    end else if (k == ldr_edge + 1) begin
    end else if (!cpu_as_n && r != 3) begin
      busy   = 1;
      err_m  = (r == 4);
      target = k + 1 + ((r == 0) ? 1 : (r == 4) ? 63 : 1);
    end else if (cpu_as_n && ldr_req) begin
      ldr_edge = k;
    end
  end

  int ram_we_cnt = 0, led_we_cnt = 0, ack_cnt = 0, ldr_wr_cnt = 0;
  int last_we_k = 0, last_ldr_k = 0;
  logic [10:0] last_addr;
  logic [15:0] last_din;
  logic [1:0]  last_mask;

  always @(posedge clk) begin
    int cr;
    bit strobe;
    logic [23:0] ba;
    #1;
    ba = {cpu_addr, 1'b0};
    cr = cpu_as_n ? 4 : region_of(ba);
    strobe = busy && !err_m && (k == target - 1) && !cpu_rw;
    chk("dtack_n", dtack_n, !(busy && !err_m && k >= target));
    chk("berr_n", berr_n, !(busy && err_m && k >= target));
    chk("vpa_n", vpa_n, !(cr == 3));
    chk("rom_cs", rom_cs, cr == 0);
    chk("rom_addr", rom_addr, (ba >> 1) & 24'hFF);
    chk("cpu_din", cpu_din, (cr == 1) ? ram_dout : rom_dout);
    chk("ram_we", ram_we, (strobe && cr == 1) || (k == ldr_edge));
    chk("led_we", led_we, strobe && cr == 2);
    chk("ldr_ack", ldr_ack, k == ldr_edge + 1);
    if (k == ldr_edge) begin
      chk("ldr_ram_addr", ram_addr, ldr_addr);
      chk("ldr_ram_din", ram_din, ldr_din);
      chk("ldr_ram_mask", ram_mask, 2'b11);
    end else if (strobe && cr == 1) begin
      chk("cpu_ram_addr", ram_addr, (ba >> 1) & 24'h7FF);
      chk("cpu_ram_din", ram_din, cpu_dout);
      chk("cpu_ram_mask", ram_mask, {!cpu_uds_n, !cpu_lds_n});
    end
    if (ram_we) begin
      ram_we_cnt++;
      last_we_k = k;
      last_addr = ram_addr;
      last_din  = ram_din;
      last_mask = ram_mask;
      if (ram_mask == 2'b11 && ram_addr == ldr_addr && ram_din == ldr_din && ldr_req) begin
        ldr_wr_cnt++;
        last_ldr_k = k;
      end
    end
    if (led_we) led_we_cnt++;
    if (ldr_ack) ack_cnt++;
  end

  int lat, dt_k;
  logic got_dt, got_be;
  logic [15:0] din_at_ack;

  task automatic bus_cycle(input logic [23:0] a, input logic rw, input logic u, input logic l,
                           input logic [15:0] d, input bit with_ldr);
    @(negedge clk);
    cpu_addr = a[23:1]; cpu_rw = rw; cpu_uds_n = u; cpu_lds_n = l; cpu_dout = d;
    cpu_as_n = 1'b0;
    if (with_ldr) ldr_req = 1'b1;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!dtack_n || !berr_n) begin lat = i; break; end
    end
    got_dt = !dtack_n; got_be = !berr_n; dt_k = k; din_at_ack = cpu_din;
    chk("cycle_terminated", lat >= 0, 1);
  endtask

  task automatic release_as();
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(posedge clk); #1;
    chk("release_dtack_n", dtack_n, 1);
    chk("release_berr_n", berr_n, 1);
  endtask

  initial begin
    int we0, led0, ack0, lw0;
    rst = 1'b1; cpu_addr = '0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_rw = 1'b1; cpu_dout = '0; rom_dout = 16'hC0DE; ram_dout = 16'h5A5A;
    ldr_req = 1'b0; ldr_addr = '0; ldr_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dtack_n", dtack_n, 1);
    chk("reset_berr_n", berr_n, 1);
    chk("reset_ldr_ack", ldr_ack, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // ROM read, one wait state
    bus_cycle(24'h000100, 1, 0, 0, 16'h0, 0);
    chk("rom_latency", lat, 2);
    chk("rom_dtack", got_dt, 1);
    chk("rom_no_berr", got_be, 0);
    chk("rom_din", din_at_ack, 16'hC0DE);
    chk("rom_addr_lit", rom_addr, 8'h80);
    release_as();

    // RAM write, upper byte only
    we0 = ram_we_cnt;
    bus_cycle(24'h001004, 0, 0, 1, 16'hBEEF, 0);
    chk("ram_wr_latency", lat, 2);
    chk("ram_wr_pulses", ram_we_cnt - we0, 1);
    chk("ram_wr_mask", last_mask, 2'b10);
    chk("ram_wr_addr", last_addr, 11'h002);
    chk("ram_wr_din", last_din, 16'hBEEF);
    chk("ram_we_before_dtack", dt_k - last_we_k, 1);
    release_as();

    // RAM read at top word
    bus_cycle(24'h001FFE, 1, 0, 0, 16'h0, 0);
    chk("ram_rd_din", din_at_ack, 16'h5A5A);
    chk("ram_rd_addr", ram_addr, 11'h7FF);
    release_as();

    // LED write
    we0 = ram_we_cnt; led0 = led_we_cnt;
    bus_cycle(24'h002000, 0, 1, 0, 16'h00A5, 0);
    chk("led_pulses", led_we_cnt - led0, 1);
    chk("led_no_ram_we", ram_we_cnt - we0, 0);
    chk("led_dtack", got_dt, 1);
    release_as();

    // Unmapped read at 0x800000
    bus_cycle(24'h800000, 1, 0, 0, 16'h0, 0);
    chk("unmapped_latency", lat, 64);
    chk("unmapped_berr", got_be, 1);
    chk("unmapped_no_dtack", got_dt, 0);
    release_as();

    // Unmapped write in low space (0x003000): bus error and no strobes
    we0 = ram_we_cnt; led0 = led_we_cnt;
    bus_cycle(24'h003000, 0, 0, 0, 16'h1111, 0);
    chk("lo_unmapped_berr", got_be, 1);
    chk("lo_unmapped_strobes", (ram_we_cnt - we0) + (led_we_cnt - led0), 0);
    release_as();

    // Just past the peripheral window
    bus_cycle(24'h640000, 1, 0, 0, 16'h0, 0);
    chk("periph_end_berr", got_be, 1);
    release_as();

    // Peripheral access: VPA only
    @(negedge clk);
    cpu_addr = 23'h300008; cpu_rw = 1'b1; cpu_as_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("periph_vpa_n", vpa_n, 0);
      chk("periph_dtack_n", dtack_n, 1);
      chk("periph_berr_n", berr_n, 1);
    end
    @(negedge clk) cpu_as_n = 1'b1;
    @(posedge clk);

    // Aborted unmapped cycle: no BERRn
    @(negedge clk);
    cpu_addr = 23'h400000; cpu_as_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) cpu_as_n = 1'b1;
    repeat (70) @(posedge clk);
    #1 chk("abort_no_berr", berr_n, 1);

    // Loader collides with a CPU cycle
    ldr_addr = 11'h7FF; ldr_din = 16'h1234;
    ack0 = ack_cnt; lw0 = ldr_wr_cnt;
    bus_cycle(24'h001000, 1, 0, 0, 16'h0, 1);
    chk("collision_cpu_first", got_dt, 1);
    chk("collision_no_ldr_yet", ldr_wr_cnt - lw0, 0);
    @(negedge clk) cpu_as_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ldr_ack) begin ldr_req = 1'b0; break; end
    end
    chk("ldr_req_dropped", ldr_req, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("ldr_ack_once", ack_cnt - ack0, 1);
    chk("ldr_write_once", ldr_wr_cnt - lw0, 1);
    chk("ldr_after_cpu", last_ldr_k > dt_k, 1);

    // Reset while in WAIT
    we0 = ram_we_cnt;
    @(negedge clk);
    cpu_addr = 23'h000808; cpu_rw = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    cpu_dout = 16'h7777; cpu_as_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst_wait_dtack_n", dtack_n, 1);
    chk("rst_wait_berr_n", berr_n, 1);
    chk("rst_wait_ldr_ack", ldr_ack, 0);
    chk("rst_wait_ram_we", ram_we, 0);
    cpu_as_n = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rst_wait_no_strobe", ram_we_cnt - we0, 0);

    // Reset while in ACK
    bus_cycle(24'h000200, 1, 0, 0, 16'h0, 0);
    chk("pre_rst_ack", got_dt, 1);
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_ack_dtack_n", dtack_n, 1);
    cpu_as_n = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    bus_cycle(24'h000000, 1, 0, 0, 16'h0, 0);
    chk("post_rst_rom_latency", lat, 2);
    release_as();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
